// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out receive path.
package sipo_pkg;

    // Frame controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Shift direction encodings, matching the dir input.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/sipo_shift_core.sv
// Plain shift register core: synchronous clear (wins over enable), then a
// one-position shift in the selected direction when enabled.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next word: clear, shift left (sin enters LSB) or right (sin enters MSB).
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            if (dir == DIR_LEFT) begin
                q_d = {q_q[WIDTH-2:0], sin};
            end else begin
                q_d = {sin, q_q[WIDTH-1:1]};
            end
        end
    end

    // Core register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Frame controller for a serial-in/parallel-out receiver. A start pulse opens
// a frame and latches the direction; exactly WIDTH qualified bits are shifted
// into the core, then the word is held on the output handshake.
//
// Output handshake: out_valid stays high with out_data stable until an edge
// on which out_valid and out_ready are both high; that edge transfers the
// word and out_valid drops the next cycle. out_ready is ignored while
// out_valid is low. Bits arriving while the word is held are dropped and
// set the sticky overrun flag.
module sipo_rx_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       dir,
    input  logic                       sin_valid,
    input  logic                       sin,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       overrun,
    output logic [1:0]                 dbg_state_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             core_clr;
    logic             core_en;
    logic [WIDTH-1:0] core_word;
    logic [WIDTH-1:0] core_shifted;

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .clr (core_clr),
        .en  (core_en),
        .dir (dir_q),
        .sin (sin),
        .q   (core_word)
    );

    // Word the core will hold after this cycle's shift; captured into the
    // output register on the final bit so out_data is valid with out_valid.
    always_comb begin
        if (dir_q == DIR_LEFT) begin
            core_shifted = {core_word[WIDTH-2:0], sin};
        end else begin
            core_shifted = {sin, core_word[WIDTH-1:1]};
        end
    end

    // Next-state, counter, overrun and core control decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        ovr_d    = ovr_q;
        data_d   = data_q;
        core_clr = 1'b0;
        core_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A bit without start is simply dropped here.
                if (start) begin
                    dir_d    = dir;
                    cnt_d    = '0;
                    ovr_d    = 1'b0;
                    core_clr = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    // Abort and restart the frame; a same-cycle bit is ignored.
                    dir_d    = dir;
                    cnt_d    = '0;
                    ovr_d    = 1'b0;
                    core_clr = 1'b1;
                end else if (sin_valid) begin
                    core_en = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        data_d  = core_shifted;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Core and word frozen; start is not queued.
                if (sin_valid) begin
                    ovr_d = 1'b1;
                end
                if (out_ready) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
            ovr_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            ovr_q   <= ovr_d;
            data_q  <= data_d;
        end
    end

    assign busy        = (state_q == ST_SHIFT);
    assign out_valid   = (state_q == ST_HOLD);
    assign bit_cnt     = cnt_q;
    assign out_data    = data_q;
    assign overrun     = ovr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl with WIDTH=8 and hand-computed words.
module tb_sipo_rx_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       dir;
    logic       sin_valid;
    logic       sin;
    logic       busy;
    logic [3:0] bit_cnt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       overrun;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    sipo_rx_ctrl #(
        .WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dir         (dir),
        .sin_valid   (sin_valid),
        .sin         (sin),
        .busy        (busy),
        .bit_cnt     (bit_cnt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .overrun     (overrun),
        .dbg_state_o (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic d);
        start = 1'b1;
        dir   = d;
        step();
        start = 1'b0;
    endtask

    // Send n bits of vec, MSB of the n-bit field first, continuous valid.
    task automatic shift_bits(input logic [7:0] vec, input int n, input int cnt0, input string tag);
        for (int k = 0; k < n; k++) begin
            sin_valid = 1'b1;
            sin       = vec[n-1-k];
            step();
            check_eq({tag, "_cnt"}, 32'(bit_cnt), 32'(cnt0 + k + 1));
            check_eq({tag, "_vld"}, 32'(out_valid), 32'((cnt0 + k + 1) == 8));
        end
        sin_valid = 1'b0;
        sin       = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_vld0"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_cnt0"}, 32'(bit_cnt), 32'd0);
        check_eq({tag, "_busy0"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0;
        sin_valid = 1'b0; sin = 1'b0; out_ready = 1'b0;
        step();
        step();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_cnt", 32'(bit_cnt), 32'd0);
        check_eq("rst_vld", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_ovr", 32'(overrun), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // Left shift, 1,0,1,1,0,0,1,0 -> 8'hB2.
        out_ready = 1'b1;
        do_start(1'b0);
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_cnt_start", 32'(bit_cnt), 32'd0);
        shift_bits(8'b1011_0010, 8, 0, "t1");
        check_eq("t1_data", 32'(out_data), 32'hB2);
        check_eq("t1_busy_hold", 32'(busy), 32'd0);
        step();
        check_idle("t1_hs");

        // Same bits, right shift -> 8'h4D.
        do_start(1'b1);
        shift_bits(8'b1011_0010, 8, 0, "t2");
        check_eq("t2_data", 32'(out_data), 32'h4D);
        step();
        check_idle("t2_hs");

        // Abort after 4 bits, restart right, 8 ones -> 8'hFF.
        do_start(1'b0);
        shift_bits(8'b0000_1010, 4, 0, "t3a");
        do_start(1'b1);
        check_eq("t3_restart_cnt", 32'(bit_cnt), 32'd0);
        check_eq("t3_restart_busy", 32'(busy), 32'd1);
        shift_bits(8'hFF, 8, 0, "t3b");
        check_eq("t3_data", 32'(out_data), 32'hFF);
        step();
        check_idle("t3_hs");

        // Hold with extra bits and an ignored start -> overrun, stable word.
        out_ready = 1'b0;
        do_start(1'b0);
        shift_bits(8'h5A, 8, 0, "t4");
        check_eq("t4_data", 32'(out_data), 32'h5A);
        for (int k = 0; k < 3; k++) begin
            sin_valid = 1'b1;
            sin       = k[0];
            start     = (k == 1);
            step();
            check_eq("t4_hold_data", 32'(out_data), 32'h5A);
            check_eq("t4_hold_vld", 32'(out_valid), 32'd1);
            check_eq("t4_hold_cnt", 32'(bit_cnt), 32'd8);
            check_eq("t4_hold_ovr", 32'(overrun), 32'd1);
        end
        sin_valid = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        check_idle("t4_hs");
        check_eq("t4_ovr_idle", 32'(overrun), 32'd1);
        out_ready = 1'b0;
        sin_valid = 1'b1;
        sin       = 1'b1;
        step();
        sin_valid = 1'b0;
        check_eq("t4_idle_bit_cnt", 32'(bit_cnt), 32'd0);
        check_eq("t4_idle_bit_ovr", 32'(overrun), 32'd1);
        check_eq("t4_idle_bit_busy", 32'(busy), 32'd0);
        do_start(1'b0);
        check_eq("t4_ovr_clr", 32'(overrun), 32'd0);

        // Reset mid-frame after 5 bits.
        shift_bits(8'b0001_0111, 5, 0, "t5a");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("t5_rst1");
        check_eq("t5_rst1_data", 32'(out_data), 32'd0);
        check_eq("t5_rst1_ovr", 32'(overrun), 32'd0);
        // Reset during HOLD with overrun set.
        do_start(1'b0);
        shift_bits(8'h96, 8, 0, "t5b");
        sin_valid = 1'b1;
        step();
        sin_valid = 1'b0;
        check_eq("t5_pre_ovr", 32'(overrun), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("t5_rst2");
        check_eq("t5_rst2_data", 32'(out_data), 32'd0);
        check_eq("t5_rst2_ovr", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        do_start(1'b0);
        shift_bits(8'hC3, 8, 0, "t5c");
        check_eq("t5_data", 32'(out_data), 32'hC3);
        step();
        check_idle("t5_hs");

        // Start with a same-cycle bit, then 8 bits with valid toggling.
        out_ready = 1'b0;
        start     = 1'b1;
        dir       = 1'b1;
        sin_valid = 1'b1;
        sin       = 1'b1;
        step();
        start = 1'b0;
        check_eq("t6_start_cnt", 32'(bit_cnt), 32'd0);
        for (int k = 0; k < 8; k++) begin
            sin_valid = 1'b1;
            sin       = k[0];
            step();
            check_eq("t6_cnt", 32'(bit_cnt), 32'(k + 1));
            check_eq("t6_vld", 32'(out_valid), 32'(k == 7));
            if (k < 7) begin
                sin_valid = 1'b0;
                sin       = 1'b1;
                step();
                check_eq("t6_gap_cnt", 32'(bit_cnt), 32'(k + 1));
                check_eq("t6_gap_vld", 32'(out_valid), 32'd0);
            end
        end
        // Right shift of 0,1,0,1,0,1,0,1: first bit at LSB -> 8'hAA.
        check_eq("t6_data", 32'(out_data), 32'hAA);
        // Bit dropped on the handshake cycle still counts as overrun.
        out_ready = 1'b1;
        sin_valid = 1'b1;
        step();
        sin_valid = 1'b0;
        check_idle("t6_hs");
        check_eq("t6_ovr", 32'(overrun), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sipo_rx_ctrl.md
# sipo_rx_ctrl

Frame-level controller for a serial-in/parallel-out shift register. It accepts a start pulse and a qualified serial bit stream, then drives a shift core with a direction latched per frame. It counts exactly WIDTH bits and presents the assembled word on a valid/ready handshake. It sits between a serial link front-end and any parallel consumer, and flags bits dropped while a word is pending.

## Interface
- WIDTH, 8: word width in bits; legal range is 2 or more.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse that opens a frame
- dir  in  1  shift direction, sampled only on an accepted start; 0 = left shift (first bit ends at MSB), 1 = right shift (first bit ends at LSB)
- sin_valid  in  1  qualifies sin this cycle
- sin  in  1  serial data bit
- busy  out  1  high in SHIFT state
- bit_cnt  out  $clog2(WIDTH+1)  number of bits shifted in the current frame
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts word
- out_data  out  WIDTH  assembled word, stable while out_valid is high
- overrun  out  1  sticky: a bit was dropped while in HOLD

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: collecting bits.
  - HOLD: word presented, waiting for the consumer.
- IDLE, start=1:
  - latch dir into dir_q
  - clear shift core and bit_cnt
  - clear overrun
  - go to SHIFT
  - a sin_valid in the same cycle is ignored.
- SHIFT, sin_valid=1 and start=0:
  - core shifts one position by dir_q: left gives {k[WIDTH-2:0],sin}; right gives {sin,k[WIDTH-1:1]}
  - bit_cnt increments.
- SHIFT, the shift that brings bit_cnt to WIDTH:
  - go to HOLD
  - out_data gets the post-shift word
  - out_valid=1.
- SHIFT, start=1: abort and restart.
  - core cleared, bit_cnt=0, dir re-latched, overrun cleared
  - stay in SHIFT
  - a sin_valid in the same cycle is ignored.
- HOLD:
  - out_valid=1; out_data and core are frozen.
  - out_ready=1 goes to IDLE and clears out_valid next cycle.
  - sin_valid=1 sets overrun and the bit is discarded. This includes the cycle where out_ready=1.
  - start is ignored and not queued.
- IDLE, sin_valid without start: bit is discarded and overrun is unchanged.
- overrun stays set until the next accepted start or reset.
- bit_cnt holds at WIDTH in HOLD and returns to 0 on entry to IDLE.

## Timing
- Reset: state=IDLE, core=0, out_data=0, out_valid=0, busy=0, bit_cnt=0, overrun=0, dir_q=0.
- rst has priority over all inputs, including mid-frame and during HOLD. A pending word is lost.
- busy rises the cycle after an accepted start.
- out_valid rises on the clock edge that samples the WIDTH-th valid bit, so it is visible the following cycle. The minimum frame is 1 start cycle plus WIDTH bit cycles.
- The handshake completes on any edge with out_valid and out_ready both high. out_ready is a don't-care while out_valid=0.
- The earliest next start is accepted in the cycle after handshake completion, when the state is IDLE.
- Back-to-back throughput is one word per WIDTH+2 cycles.
- Gaps in sin_valid are allowed at any point during SHIFT, with no timeout.

## Structure
- Shared package sipo_pkg:
  - state enum {ST_IDLE, ST_SHIFT, ST_HOLD}
  - direction constants DIR_LEFT=0, DIR_RIGHT=1.
- Sub-module sipo_shift_core #(WIDTH):
  - ports clk, rst, clr, en, dir, sin, q
  - synchronous clr, which has priority over en.
  - The controller instantiates it and keeps the FSM, counter, output register and overrun flag.

## Test plan
- WIDTH=8, dir=0, start, then bits 1,0,1,1,0,0,1,0 with continuous valid and out_ready=1. Required: out_data=8'hB2, out_valid high exactly one cycle, bit_cnt goes 0..8.
- Same bits with dir=1. Required: out_data=8'h4D.
- start, 4 bits, then start again with dir=1, then 8 bits of 1. Required: out_data=8'hFF, only one out_valid.
- Complete a frame with out_ready=0 and drive 3 extra valid bits during HOLD. Required:
  - out_data stays stable and overrun=1
  - raising out_ready gives IDLE next cycle
  - overrun stays 1 until the next start clears it.
- Assert rst after 5 bits, then assert rst again during HOLD. Required: all outputs 0 the following cycle, and a new 8-bit frame completes correctly.
- start with sin_valid=1 in the same cycle, then 8 bits, with sin_valid toggling 1-0-1. Required: the start-cycle bit is excluded and out_valid appears exactly after the 8th valid bit.
